aes_state_buffer: RTL and testbench
===================================

# aes_state_buffer

Parametrised successor to the team's 16×8 byte RAM, used as the AES state/round-key store. It keeps the byte-addressed read/write port and adds:
- a parallel block load/view of the whole array;
- a synchronous clear;
- a valid/ready streaming read-out in either linear or row-major (transposed) order.

It sits between the round datapath, which loads and views whole blocks, and the serial output interface, which consumes one entry per handshake.

## Interface
- DATA_W, 8, entry width in bits
- DEPTH, 16, number of entries; power of two, multiple of ROWS
- ROWS, 4, state rows; COLS = DEPTH/ROWS
- ADDR_W, $clog2(DEPTH), address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  byte write enable
- addr  in  ADDR_W  byte port address
- wr_data  in  DATA_W  byte write data
- rd_data  out  DATA_W  combinational read, RAM[addr]
- blk_ld  in  1  parallel load of all entries
- blk_in  in  DEPTH*DATA_W  entry i = blk_in[i*DATA_W +: DATA_W]
- blk_out  out  DEPTH*DATA_W  combinational view of all entries, same packing
- clr  in  1  synchronous clear of all entries
- str_start  in  1  start a stream read-out
- str_mode  in  1  0 = linear order, 1 = row-major order; sampled with str_start
- str_valid  out  1  stream data valid
- str_ready  in  1  consumer ready
- str_data  out  DATA_W  current stream entry
- str_last  out  1  str_valid and final entry
- busy  out  1  stream in progress

## Operation
- Storage: DEPTH × DATA_W registers.
- Priority in IDLE: clr > blk_ld > wr_en. At most one of these takes effect per cycle.
- While busy, clr, blk_ld and wr_en are ignored and the array is frozen. rd_data and blk_out remain readable.
- FSM has two states, IDLE and SEND.
  - IDLE → SEND on str_start. The cycle's write and clear actions still apply. Mode is latched and cnt is set to 0.
  - In SEND, str_valid = 1. A transfer occurs on str_valid & str_ready, and each transfer increments cnt.
  - A transfer with cnt == DEPTH-1 returns the FSM to IDLE.
  - str_start is ignored in SEND, including on the final-transfer cycle.
- Stream index for count k:
  - linear: k;
  - row-major: (k mod COLS)*ROWS + k/COLS. This is AES column-major storage read out row by row.
- str_data = RAM[index(cnt)], combinational from the latched mode and cnt.
- str_data and str_valid hold steady while str_valid & !str_ready.
- busy = (state == SEND). str_last = str_valid & (cnt == DEPTH-1).
- cnt width is ADDR_W. cnt never wraps during a stream because it exits at DEPTH-1.

## Timing
- Reset state (async, immediate): all entries 0, state IDLE, cnt 0, latched mode 0.
  - Outputs: str_valid 0, str_last 0, busy 0, rd_data 0, blk_out 0, str_data 0.
- Write latency:
  - a write at edge N is visible on rd_data and blk_out after edge N;
  - same-cycle read-during-write returns the old data.
- Stream timing:
  - str_start sampled at edge N gives str_valid = 1 after edge N;
  - the first entry reflects any write accepted at edge N;
  - with str_ready held at 1, DEPTH transfers take DEPTH cycles;
  - busy falls after the edge of the final transfer;
  - the earliest next accepted start is the edge after that.
- Reset asserted mid-stream aborts immediately: IDLE, array cleared, no further str_valid.

## Structure
- Shared package aes_pkg: AES_ROWS = 4, AES_BLOCK_BYTES = 16, and function state_idx(k, mode, ROWS, COLS) returning the stream index.
- One sub-module, aes_state_ram_core: the register array with clear/block-load/byte-write priority, async-reset clear, and the combinational rd_data, blk_out and indexed read ports.
- The FSM and counter live in the top module.

## Test plan
- Reset, then write 0xA5 to addr 3 → rd_data = 0xA5 at addr 3 next cycle; blk_out byte 3 = 0xA5, all others 0.
- blk_ld with blk_in entry i = i, with wr_en to addr 0 (data 0xFF) and clr both low → entries 0x00..0x0F. Repeat with wr_en and blk_ld together → blk_ld wins. Repeat with clr also high → all zero.
- After load i, str_start, str_mode = 0, str_ready = 1 → str_data 0x00..0x0F on consecutive cycles; str_last only with 0x0F; busy low after.
- After load i, str_mode = 1 → order 0x00, 0x04, 0x08, 0x0C, 0x01, 0x05, …, 0x0F.
- Mid-stream, str_ready toggles 1,0,0,1, and wr_en, blk_ld and clr are asserted → data held while ready = 0; array unchanged; str_start ignored.
- Assert rst low at transfer 7 → str_valid, busy and blk_out go 0 immediately; the next stream after a new load starts at index 0.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state geometry, FSM states and stream index mapping.
package aes_pkg;
  localparam int AES_ROWS = 4;
  localparam int AES_BLOCK_BYTES = 16;
  typedef enum logic {S_IDLE, S_SEND} state_e;
  // Storage is column-major, so row-major read-out walks one row across all columns.
  function automatic int unsigned state_idx(input int unsigned k, input logic mode,
                                            input int unsigned rows, input int unsigned cols);
    return mode ? (k % cols) * rows + k / cols : k;
  endfunction
endpackage

// File: rtl/aes_state_ram_core.sv
// aes_state_ram_core: entry register array with clear/block-load/byte-write and combinational reads.
module aes_state_ram_core #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    blk_ld,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [DEPTH*DATA_W-1:0] blk_in,
  input  logic [ADDR_W-1:0]       idx,
  output logic [DATA_W-1:0]       rd_data,
  output logic [DEPTH*DATA_W-1:0] blk_out,
  output logic [DATA_W-1:0]       idx_data
);
  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (en) begin
      if (clr) mem_d = '0;
      else if (blk_ld) mem_d = blk_in;
      else if (wr_en) mem_d[addr] = wr_data;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_q <= '0;
    else mem_q <= mem_d;
  end
  assign rd_data  = mem_q[addr];
  assign blk_out  = mem_q;
  assign idx_data = mem_q[idx];
endmodule

// File: rtl/aes_state_buffer.sv
// aes_state_buffer: AES state/round-key store with byte port, block port and
// a valid/ready stream read-out in linear or row-major order.
module aes_state_buffer
  import aes_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = AES_BLOCK_BYTES,
  parameter int ROWS   = AES_ROWS,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [DATA_W-1:0]       rd_data,
  input  logic                    blk_ld,
  input  logic [DEPTH*DATA_W-1:0] blk_in,
  output logic [DEPTH*DATA_W-1:0] blk_out,
  input  logic                    clr,
  input  logic                    str_start,
  input  logic                    str_mode,
  output logic                    str_valid,
  input  logic                    str_ready,
  output logic [DATA_W-1:0]       str_data,
  output logic                    str_last,
  output logic                    busy
);
  localparam int COLS = DEPTH / ROWS;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, idx;
  logic mode_q, mode_d;
  assign idx = ADDR_W'(state_idx(32'(cnt_q), mode_q, ROWS, COLS));
  aes_state_ram_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_core (
    .clk(clk), .rst(rst), .en(state_q == S_IDLE), .clr(clr), .blk_ld(blk_ld),
    .wr_en(wr_en), .addr(addr), .wr_data(wr_data), .blk_in(blk_in), .idx(idx),
    .rd_data(rd_data), .blk_out(blk_out), .idx_data(str_data)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (state_q == S_IDLE) begin
      if (str_start) begin
        state_d = S_SEND;
        cnt_d   = '0;
        mode_d  = str_mode;
      end
    end else if (str_ready) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? S_IDLE : S_SEND;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end
  assign busy      = state_q == S_SEND;
  assign str_valid = busy;
  assign str_last  = busy && cnt_q == LAST;
endmodule

// File: tb/tb_aes_state_buffer.sv
// tb_aes_state_buffer: directed stimulus with a queue-based stream scoreboard.
module tb_aes_state_buffer;
  logic         clk = 0, rst = 0;
  logic         wr_en = 0, blk_ld = 0, clr = 0, str_start = 0, str_mode = 0, str_ready = 0;
  logic [3:0]   addr = 0;
  logic [7:0]   wr_data = 0, rd_data, str_data;
  logic [127:0] blk_in = 0, blk_out, inc, exp_blk;
  logic         str_valid, str_last, busy;
  logic [8:0]   sb_q[$];
  logic [8:0]   ent;
  int           checks = 0, failures = 0;
  byte unsigned rm_tbl[16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h01, 8'h05, 8'h09, 8'h0D,
                               8'h02, 8'h06, 8'h0A, 8'h0E, 8'h03, 8'h07, 8'h0B, 8'h0F};

  aes_state_buffer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .blk_ld(blk_ld), .blk_in(blk_in), .blk_out(blk_out), .clr(clr), .str_start(str_start),
    .str_mode(str_mode), .str_valid(str_valid), .str_ready(str_ready), .str_data(str_data),
    .str_last(str_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_linear(input int n);
    for (int k = 0; k < n; k++) sb_q.push_back({k == 15, 8'(k)});
  endtask

  // Monitor: every handshake must match the next expected entry and its last flag.
  always @(negedge clk) begin
    if (rst && str_valid && str_ready) begin
      if (sb_q.size() == 0) chk("stream_unexpected", {str_last, str_data}, 9'h1FF);
      else begin
        ent = sb_q.pop_front();
        chk("stream_data", str_data, ent[7:0]);
        chk("stream_last", str_last, ent[8]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) inc[i*8 +: 8] = 8'(i);
    #2;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_blk_out", blk_out, 0);
    chk("rst_valid", str_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last", str_last, 0);
    chk("rst_str_data", str_data, 0);
    step();
    rst = 1;
    step();
    wr_en = 1; addr = 3; wr_data = 8'hA5;
    #1 chk("rd_during_wr_old", rd_data, 0);
    step();
    wr_en = 0;
    chk("wr_rd_data", rd_data, 8'hA5);
    exp_blk = 0; exp_blk[31:24] = 8'hA5;
    chk("wr_blk_out", blk_out, exp_blk);
    blk_in = inc; blk_ld = 1;
    step();
    chk("blk_ld", blk_out, inc);
    wr_en = 1; addr = 0; wr_data = 8'hFF;
    step();
    chk("blk_ld_over_wr", blk_out, inc);
    clr = 1;
    step();
    chk("clr_over_all", blk_out, 0);
    clr = 0; wr_en = 0;
    step();
    blk_ld = 0;
    chk("reload", blk_out, inc);
    // Linear stream at full rate.
    push_linear(16);
    str_start = 1; str_mode = 0; str_ready = 1;
    step();
    str_start = 0;
    chk("lin_busy", busy, 1);
    chk("lin_first_last", str_last, 0);
    repeat (15) step();
    chk("lin_final_data", str_data, 8'h0F);
    chk("lin_final_last", str_last, 1);
    step();
    chk("lin_busy_after", busy, 0);
    chk("lin_sb_empty", sb_q.size(), 0);
    // Row-major stream.
    for (int k = 0; k < 16; k++) sb_q.push_back({k == 15, rm_tbl[k]});
    str_start = 1; str_mode = 1;
    step();
    str_start = 0; str_mode = 0;
    chk("rm_second_idx", blk_out[8*4 +: 8], 8'h04);
    repeat (16) step();
    chk("rm_busy_after", busy, 0);
    chk("rm_sb_empty", sb_q.size(), 0);
    // Back-pressure with writes, loads, clears and restarts attempted mid-stream.
    push_linear(16);
    str_start = 1;
    step();
    step();
    str_ready = 0; wr_en = 1; addr = 5; wr_data = 8'hEE; blk_ld = 1; blk_in = '1; clr = 1;
    chk("stall_data0", str_data, 8'h01);
    step();
    chk("stall_data1", str_data, 8'h01);
    chk("stall_valid", str_valid, 1);
    step();
    chk("stall_blk_frozen", blk_out, inc);
    str_ready = 1;
    for (int i = 0; i < 40 && busy; i++) step();
    chk("stall_done", busy, 0);
    chk("stall_array_kept", blk_out, inc);
    chk("stall_sb_empty", sb_q.size(), 0);
    str_start = 0; wr_en = 0; blk_ld = 0; clr = 0; blk_in = inc;
    step();
    chk("start_ignored", busy, 0);
    // Reset aborts a stream at transfer 7.
    push_linear(7);
    str_start = 1;
    step();
    str_start = 0;
    repeat (7) step();
    chk("abort_pre_data", str_data, 8'h07);
    rst = 0;
    #1;
    chk("abort_valid", str_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_blk_out", blk_out, 0);
    chk("abort_sb_empty", sb_q.size(), 0);
    step();
    rst = 1;
    blk_ld = 1;
    step();
    blk_ld = 0;
    push_linear(16);
    str_start = 1;
    step();
    str_start = 0;
    chk("restart_first", str_data, 8'h00);
    for (int i = 0; i < 40 && busy; i++) step();
    chk("restart_done", busy, 0);
    chk("restart_sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
